// File: rtl/ssd_scan_driver_if.sv
// Bus bundle between the display client (game/status logic) and the scan driver.
// The client side drives the digit data and load strobe; the driver side returns
// the pin drives plus scan position and frame marker.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   en_i;
  logic                    load_i;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [6:0]              seg_o;
  logic                    dp_o;
  logic [IDX_W-1:0]        scan_idx_o;
  logic                    frame_o;

  modport master (
    output digits_i, dp_i, en_i, load_i,
    input  an_o, seg_o, dp_o, scan_idx_o, frame_o
  );

  modport slave (
    input  digits_i, dp_i, en_i, load_i,
    output an_o, seg_o, dp_o, scan_idx_o, frame_o
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver for NUM_DIGITS hex digits.
// Each digit owns a slot of 2**SLOT_BITS cycles; the first BLANK_CYCLES of every
// slot are dark so anode and cathode transitions never overlap (no ghosting).
// Digit data is double buffered: loads land in staging and are promoted to the
// displayed set only at the frame boundary, so a frame never mixes two loads.
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_BITS    = 18,
  parameter int BLANK_CYCLES = 64,
  parameter bit AN_ACT_LOW   = 1'b1,
  parameter bit SEG_ACT_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  ssd_scan_driver_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACT_LOW  ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = SEG_ACT_LOW ? '1 : '0;
  localparam logic                  DP_OFF  = SEG_ACT_LOW;

  logic [SLOT_BITS-1:0]    slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    frame_q, frame_d;

  logic [4*NUM_DIGITS-1:0] stg_digits_q, stg_digits_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]   stg_en_q, stg_en_d;
  logic                    pending_q, pending_d;

  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    slot_wrap;
  logic                    idx_wrap;
  logic                    lit;
  logic [3:0]              nibble;
  logic [6:0]              glyph;

  // Hex nibble to active-high {a,b,c,d,e,f,g} pattern.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1111110;
      4'h1: hex_glyph = 7'b0110000;
      4'h2: hex_glyph = 7'b1101101;
      4'h3: hex_glyph = 7'b1111001;
      4'h4: hex_glyph = 7'b0110011;
      4'h5: hex_glyph = 7'b1011011;
      4'h6: hex_glyph = 7'b1011111;
      4'h7: hex_glyph = 7'b1110000;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1111011;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b0011111;
      4'hC: hex_glyph = 7'b1001110;
      4'hD: hex_glyph = 7'b0111101;
      4'hE: hex_glyph = 7'b1001111;
      default: hex_glyph = 7'b1000111;
    endcase
  endfunction

  assign slot_wrap = &slot_cnt_q;
  assign idx_wrap  = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Slot timer, digit index and frame marker.
  always_comb begin
    slot_cnt_d = slot_cnt_q + SLOT_BITS'(1);
    idx_d      = idx_q;
    frame_d    = idx_wrap;
    if (slot_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Staging capture and frame-boundary promotion; a load on the boundary
  // cycle bypasses staging so it is shown without a frame of lag.
  always_comb begin
    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_en_d     = stg_en_q;
    pending_d    = pending_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    if (bus.load_i) begin
      stg_digits_d = bus.digits_i;
      stg_dp_d     = bus.dp_i;
      stg_en_d     = bus.en_i;
      pending_d    = 1'b1;
    end
    if (idx_wrap && (pending_q || bus.load_i)) begin
      act_digits_d = bus.load_i ? bus.digits_i : stg_digits_q;
      act_dp_d     = bus.load_i ? bus.dp_i     : stg_dp_q;
      act_en_d     = bus.load_i ? bus.en_i     : stg_en_q;
      pending_d    = 1'b0;
    end
  end

  // Pin drive for the current slot; registered so outputs lag the index by one cycle.
  always_comb begin
    lit    = (slot_cnt_q >= SLOT_BITS'(BLANK_CYCLES)) && act_en_q[idx_q];
    nibble = act_digits_q[{idx_q, 2'b00} +: 4];
    glyph  = hex_glyph(nibble);
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    if (lit) begin
      an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
      seg_d = glyph ^ SEG_OFF;
      dp_d  = act_dp_q[idx_q] ^ DP_OFF;
    end
  end

  // State and output registers; reset darkens the display and drops pending loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      frame_q      <= 1'b0;
      stg_digits_q <= '0;
      stg_dp_q     <= '0;
      stg_en_q     <= '0;
      pending_q    <= 1'b0;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      stg_digits_q <= stg_digits_d;
      stg_dp_q     <= stg_dp_d;
      stg_en_q     <= stg_en_d;
      pending_q    <= pending_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an_o       = an_q;
  assign bus.seg_o      = seg_q;
  assign bus.dp_o       = dp_q;
  assign bus.scan_idx_o = idx_q;
  assign bus.frame_o    = frame_q;

endmodule
